// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: widths, NOP encoding, boot/trap vectors, fetch FSM states.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP            = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StWait,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding register. It parks a fetch response that arrives while ID is
// stalled. Clear has priority over load, and load has priority over unload.
module if_skid_buf
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  // Entry storage with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= INSTR_NOP;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= load_pc;
      instr_q <= load_instr;
    end else if (unload) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32 instruction-fetch stage: owns the PC, issues one-outstanding word fetches over a
// valid/ready request and valid response interface, and drives the IF/ID register.
// Optional build macro IF_MISALIGN_CHECK_EN: a misaligned jump target raises a one-cycle
// misalign_exc and redirects fetch to TRAP_VECTOR. Without it, target bits [1:0] are ignored.
module if_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            take_jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  // PC of the outstanding request; also holds a stuck request address after a redirect in REQ
  logic [XLEN-1:0] req_pc_q;
  logic            drop_q;

  logic            if_valid_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;

  logic            rsp_take;
  logic            b2b_req;
  logic            req_fire;
  logic [XLEN-1:0] redirect_pc;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;
  logic            skid_load;
  logic            skid_unload;

  // A response that will actually be used (not squashed by drop or a redirect)
  assign rsp_take = (state_q == StWait) && imem_rsp_valid && !drop_q && !take_jump;
  assign b2b_req  = rsp_take && !stall_i;
  assign req_fire = imem_req_valid && imem_req_ready;

  // Request drive: a request already presented keeps its address until accepted
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_q;
    unique case (state_q)
      StReq: begin
        imem_req_valid = 1'b1;
        imem_req_addr  = drop_q ? req_pc_q : pc_q;
      end
      StWait:  imem_req_valid = b2b_req;
      default: imem_req_valid = 1'b0;
    endcase
  end

`ifdef IF_MISALIGN_CHECK_EN
  logic            misaligned;
  logic            misalign_exc_q;
  logic [XLEN-1:0] misalign_addr_q;

  assign misaligned  = (jump_target[1:0] != 2'b00);
  assign redirect_pc = misaligned ? TRAP_VECTOR : jump_target;

  // One-cycle exception pulse; the address stays until the next misaligned jump
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_exc_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_exc_q <= take_jump && misaligned;
      if (take_jump && misaligned) begin
        misalign_addr_q <= jump_target;
      end
    end
  end

  assign misalign_exc  = misalign_exc_q;
  assign misalign_addr = misalign_addr_q;
`else
  logic unused_tgt_lsbs;
  logic unused_trap_vec;

  assign unused_tgt_lsbs = ^jump_target[1:0];
  assign unused_trap_vec = ^TRAP_VECTOR;
  assign redirect_pc     = {jump_target[XLEN-1:2], 2'b00};
  assign misalign_exc    = 1'b0;
  assign misalign_addr   = '0;
`endif

  // Fetch FSM: PC, outstanding-request bookkeeping and wrong-path drop flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StBoot;
      pc_q     <= RESET_VECTOR;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
    end else if (take_jump) begin
      pc_q <= redirect_pc;
      unique case (state_q)
        StBoot: state_q <= StReq;
        StReq: begin
          // The presented request cannot be withdrawn; its response gets dropped
          drop_q <= 1'b1;
          if (imem_req_ready) begin
            state_q <= StWait;
          end else if (!drop_q) begin
            req_pc_q <= pc_q;
          end
        end
        StWait: begin
          if (imem_rsp_valid) begin
            drop_q  <= 1'b0;
            state_q <= StReq;
          end else begin
            drop_q <= 1'b1;
          end
        end
        StHold: state_q <= StReq;
      endcase
    end else begin
      unique case (state_q)
        StBoot: state_q <= StReq;
        StReq: begin
          if (imem_req_ready) begin
            state_q <= StWait;
            // With drop set, pc already holds the redirect target
            if (!drop_q) begin
              req_pc_q <= pc_q;
              pc_q     <= pc_q + 32'd4;
            end
          end
        end
        StWait: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= StReq;
            end else if (stall_i) begin
              state_q <= StHold;
            end else if (req_fire) begin
              req_pc_q <= pc_q;
              pc_q     <= pc_q + 32'd4;
            end else begin
              state_q <= StReq;
            end
          end
        end
        StHold: begin
          if (!stall_i) begin
            state_q <= StReq;
          end
        end
      endcase
    end
  end

  assign skid_load   = rsp_take && stall_i;
  assign skid_unload = (state_q == StHold) && !stall_i && !take_jump;

  if_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (take_jump),
    .load_pc    (req_pc_q),
    .load_instr (imem_rsp_data),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // IF/ID register: redirect flushes, stall holds, otherwise new instruction or bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= INSTR_NOP;
    end else if (take_jump) begin
      if_valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (rsp_take) begin
        if_valid_q <= 1'b1;
        if_pc_q    <= req_pc_q;
        if_instr_q <= imem_rsp_data;
      end else if (state_q == StHold) begin
        if_valid_q <= skid_valid;
        if_pc_q    <= skid_pc;
        if_instr_q <= skid_instr;
      end else begin
        if_valid_q <= 1'b0;
      end
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a one-cycle instruction memory model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        take_jump;
  logic [31:0] jump_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_exc;
  logic [31:0] misalign_addr;

  int errors = 0;
  int checks = 0;

  // Memory model state
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        rsp_hold  = 1'b0;
  logic        last_req_v;
  logic [31:0] last_req_addr;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .take_jump      (take_jump),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_exc   (misalign_exc),
    .misalign_addr  (misalign_addr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // One clock: deliver any pending response, sample the request, advance to the next negedge
  task automatic step();
    imem_rsp_valid = pend && !rsp_hold;
    imem_rsp_data  = (pend && !rsp_hold) ? instr_of(pend_addr) : 32'h0;
    if (pend && !rsp_hold) pend = 1'b0;
    #1;
    last_req_v    = imem_req_valid;
    last_req_addr = imem_req_addr;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 1'b0; take_jump = 1'b0; jump_target = '0;
    imem_req_ready = 1'b1; rsp_hold = 1'b0; pend = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Reset release, first request (0x0) and responses 0x0, 0x4; IF/ID shows 0x4 afterwards
  task automatic warm_up();
    do_reset();
    step(); step(); step(); step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h13) begin
      errors++;
      $display("FAIL reset_ifid: got v=%b pc=%h instr=%h want v=0 pc=0 instr=00000013",
               if_valid, if_pc, if_instr);
    end
    checks++;
    if (imem_req_valid !== 1'b0 || misalign_exc !== 1'b0 || misalign_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs: got req_v=%b exc=%b maddr=%h want 0 0 0",
               imem_req_valid, misalign_exc, misalign_addr);
    end
    // Reset in the middle of traffic with a request outstanding
    warm_up();
    step();
    do_reset();
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: got if_valid=%b req_v=%b want 0 0", if_valid, imem_req_valid);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    do_reset();
    step();
    checks++;
    if (last_req_v !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req: got req_v=%b want 0", last_req_v);
    end
    step();
    checks++;
    if (last_req_v !== 1'b1 || last_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: got v=%b addr=%h want v=1 addr=00000000",
               last_req_v, last_req_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc[i] || if_instr !== instr_of(exp_pc[i])) begin
        errors++;
        $display("FAIL seq_pc[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i,
                 if_valid, if_pc, if_instr, exp_pc[i], instr_of(exp_pc[i]));
      end
    end
  endtask

  task automatic test_stall();
    warm_up();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4 || last_req_v !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h req_v=%b want v=1 pc=00000004 req_v=0",
                 i, if_valid, if_pc, last_req_v);
      end
    end
    stall_i = 1'b0;
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== instr_of(32'h8)) begin
      errors++;
      $display("FAIL stall_release: got v=%b pc=%h instr=%h want v=1 pc=00000008 instr=%h",
               if_valid, if_pc, if_instr, instr_of(32'h8));
    end
    step();
    checks++;
    if (if_valid !== 1'b0 || last_req_v !== 1'b1 || last_req_addr !== 32'hC) begin
      errors++;
      $display("FAIL stall_next_req: got if_v=%b req_v=%b addr=%h want 0 1 0000000c",
               if_valid, last_req_v, last_req_addr);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hC) begin
      errors++;
      $display("FAIL stall_after: got v=%b pc=%h want v=1 pc=0000000c", if_valid, if_pc);
    end
  endtask

  task automatic test_jump_inflight();
    warm_up();
    step();
    step();
    checks++;
    if (last_req_addr !== 32'h10 || if_pc !== 32'hC) begin
      errors++;
      $display("FAIL jf_setup: got req_addr=%h if_pc=%h want 00000010 0000000c",
               last_req_addr, if_pc);
    end
    rsp_hold = 1'b1; take_jump = 1'b1; jump_target = 32'h200;
    step();
    rsp_hold = 1'b0; take_jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (if_valid !== 1'b0) begin
        errors++;
        $display("FAIL jf_bubble[%0d]: got if_valid=%b pc=%h want 0", i, if_valid, if_pc);
      end
      if (i == 1) begin
        checks++;
        if (last_req_v !== 1'b0) begin
          errors++;
          $display("FAIL jf_no_req: got req_v=%b want 0", last_req_v);
        end
      end
      if (i == 2) begin
        checks++;
        if (last_req_v !== 1'b1 || last_req_addr !== 32'h200) begin
          errors++;
          $display("FAIL jf_tgt_req: got v=%b addr=%h want 1 00000200", last_req_v,
                   last_req_addr);
        end
      end
      if (i < 2) step();
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== instr_of(32'h200)) begin
      errors++;
      $display("FAIL jf_target: got v=%b pc=%h instr=%h want v=1 pc=00000200",
               if_valid, if_pc, if_instr);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h204) begin
      errors++;
      $display("FAIL jf_target_next: got v=%b pc=%h want v=1 pc=00000204", if_valid, if_pc);
    end
  endtask

  task automatic test_jump_rsp_stall();
    warm_up();
    stall_i = 1'b1; take_jump = 1'b1; jump_target = 32'h300;
    step();
    stall_i = 1'b0; take_jump = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || last_req_v !== 1'b0) begin
      errors++;
      $display("FAIL jrs_flush: got if_v=%b req_v=%b want 0 0", if_valid, last_req_v);
    end
    step();
    checks++;
    if (last_req_v !== 1'b1 || last_req_addr !== 32'h300 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL jrs_req: got req_v=%b addr=%h if_v=%b want 1 00000300 0",
               last_req_v, last_req_addr, if_valid);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h300) begin
      errors++;
      $display("FAIL jrs_target: got v=%b pc=%h want v=1 pc=00000300", if_valid, if_pc);
    end
  endtask

  task automatic test_ready_low();
    warm_up();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (last_req_v !== 1'b1 || last_req_addr !== 32'hC ||
          if_valid !== ((i == 0) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL rdy_low[%0d]: got req_v=%b addr=%h if_v=%b want 1 0000000c %b", i,
                 last_req_v, last_req_addr, if_valid, (i == 0));
      end
    end
    imem_req_ready = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b0 || last_req_addr !== 32'hC) begin
      errors++;
      $display("FAIL rdy_accept: got if_v=%b addr=%h want 0 0000000c", if_valid, last_req_addr);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hC) begin
      errors++;
      $display("FAIL rdy_resume: got v=%b pc=%h want v=1 pc=0000000c", if_valid, if_pc);
    end
  endtask

  task automatic test_misalign();
    logic        exp_exc;
    logic [31:0] exp_addr;
`ifdef IF_MISALIGN_CHECK_EN
    exp_exc = 1'b1; exp_addr = 32'h102;
`else
    exp_exc = 1'b0; exp_addr = 32'h0;
`endif
    warm_up();
    take_jump = 1'b1; jump_target = 32'h102;
    step();
    take_jump = 1'b0;
    checks++;
    if (misalign_exc !== exp_exc || misalign_addr !== exp_addr || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse: got exc=%b addr=%h if_v=%b want %b %h 0",
               misalign_exc, misalign_addr, if_valid, exp_exc, exp_addr);
    end
    step();
    checks++;
    if (misalign_exc !== 1'b0 || last_req_v !== 1'b1 || last_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL mis_fetch: got exc=%b req_v=%b addr=%h want 0 1 00000100",
               misalign_exc, last_req_v, last_req_addr);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
      errors++;
      $display("FAIL mis_target: got v=%b pc=%h want v=1 pc=00000100", if_valid, if_pc);
    end
  endtask

  task automatic test_pc_wrap();
    warm_up();
    take_jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    take_jump = 1'b0;
    step();
    checks++;
    if (last_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req: got addr=%h want fffffffc", last_req_addr);
    end
    step();
    checks++;
    if (last_req_v !== 1'b1 || last_req_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_next: got req_v=%b addr=%h if_pc=%h want 1 00000000 fffffffc",
               last_req_v, last_req_addr, if_pc);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_ifid: got v=%b pc=%h want v=1 pc=00000000", if_valid, if_pc);
    end
  endtask

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_jump_inflight();
    test_jump_rsp_stall();
    test_ready_low();
    test_misalign();
    test_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
